// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC owner, combinational imem address, prefetch FIFO.
// Redirect from execute flushes the FIFO and restarts fetch at the new target.
module fetch_unit #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic [15:0]                        imem_addr,
  input  logic [15:0]                        imem_instr,
  input  logic                               redirect_valid,
  input  logic [15:0]                        redirect_pc,
  output logic                               if_valid,
  output logic [15:0]                        if_instr,
  output logic [15:0]                        if_pc,
  input  logic                               if_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [15:0] START_PC = RESET_PC & 16'hFFFE;

  logic [15:0]   fetch_pc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [15:0]   buf_instr [FIFO_DEPTH];
  logic [15:0]   buf_pc    [FIFO_DEPTH];
  logic          full;
  logic          pop;
  logic          push;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign if_valid   = (count != '0);
  assign pop        = if_valid & if_ready;
  assign push       = !redirect_valid & (!full | pop);
  assign imem_addr  = fetch_pc;
  assign fifo_count = count;
  assign if_instr   = if_valid ? buf_instr[rd_ptr] : 16'h0000;
  assign if_pc      = if_valid ? buf_pc[rd_ptr] : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= START_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect_valid) begin
      // a same-cycle pop is already consumed by decode; drop the rest
      fetch_pc <= redirect_pc & 16'hFFFE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        fetch_pc <= fetch_pc + 16'd2;
        wr_ptr   <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage needs no reset: occupancy gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      buf_instr[wr_ptr] <= imem_instr;
      buf_pc[wr_ptr]    <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues expected PCs,
// a negedge monitor pops and compares every accepted instruction.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic [15:0] imem_instr;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        if_ready;
  logic [2:0]  fifo_count;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] img(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  assign imem_instr = img(imem_addr);

  fetch_unit #(.RESET_PC(16'h0000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop got pc %h expected none", if_pc);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check("pop_pc", 32'(if_pc), 32'(e));
        check("pop_instr", 32'(if_instr), 32'(img(e)));
      end
    end
  end

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s timeout got %0d left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic push_seq(input logic [15:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 16'(2 * i));
  endtask

  initial begin
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    if_ready       = 1'b0;
    #1;
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_valid", 32'(if_valid), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // backpressure from start
    @(negedge clk);
    check("bp_first_valid", 32'(if_valid), 32'h0);
    @(negedge clk);
    check("bp_valid", 32'(if_valid), 32'h1);
    check("bp_pc0", 32'(if_pc), 32'h0);
    repeat (5) @(negedge clk);
    check("bp_count", 32'(fifo_count), 32'd4);
    check("bp_addr", 32'(imem_addr), 32'h0008);
    check("bp_pc_hold", 32'(if_pc), 32'h0000);
    check("bp_instr_hold", 32'(if_instr), 32'(img(16'h0000)));
    push_seq(16'h0000, 5);
    @(posedge clk);
    #1 if_ready = 1'b1;
    @(negedge clk);
    check("full_pop_count0", 32'(fifo_count), 32'd4);
    check("full_pop_addr0", 32'(imem_addr), 32'h0008);
    @(negedge clk);
    check("full_pop_count1", 32'(fifo_count), 32'd4);
    check("full_pop_addr1", 32'(imem_addr), 32'h000A);
    wait_drain("bp_drain");
    @(posedge clk);
    #1 if_ready = 1'b0;

    // async reset mid-run
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_addr", 32'(imem_addr), 32'h0);
    check("mid_rst_valid", 32'(if_valid), 32'h0);
    check("mid_rst_count", 32'(fifo_count), 32'h0);
    check("mid_rst_pc", 32'(if_pc), 32'h0);

    // streaming with ready held high
    if_ready = 1'b1;
    push_seq(16'h0000, 6);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("st_first_valid", 32'(if_valid), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("st_count", 32'(fifo_count), 32'd1);
    end
    wait_drain("st_drain");
    @(posedge clk);
    #1 if_ready = 1'b0;

    // redirect with three entries queued
    rst_n = 1'b0;
    #1 exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rd_count3", 32'(fifo_count), 32'd3);
    exp_q.push_back(16'h0000);
    push_seq(16'h0100, 3);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0101;
    if_ready       = 1'b1;
    @(posedge clk);
    #1 redirect_valid = 1'b0;
    @(negedge clk);
    check("rd_addr", 32'(imem_addr), 32'h0100);
    check("rd_valid0", 32'(if_valid), 32'h0);
    check("rd_count0", 32'(fifo_count), 32'h0);
    @(negedge clk);
    check("rd_valid1", 32'(if_valid), 32'h1);
    check("rd_pc1", 32'(if_pc), 32'h0100);
    wait_drain("rd_drain");
    @(posedge clk);
    #1 if_ready = 1'b0;

    // back-to-back redirects, last one wraps through 0xFFFE
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 16'h2000;
    @(posedge clk);
    #1 redirect_pc = 16'hFFFD;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    check("wrap_addr", 32'(imem_addr), 32'hFFFC);
    push_seq(16'hFFFC, 4);
    if_ready = 1'b1;
    wait_drain("wrap_drain");
    @(posedge clk);
    #1 if_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
